// File: rtl/audio_splitter.sv
// audio_splitter
//   Deinterleaves a serial stream of WIDTH-bit samples (channel order 0..3)
//   into one four-channel frame. One frame is assembled while the previous
//   frame is held at the output. A valid/ready handshake is used on both sides.
//
// Ports:
//   clk, resetn              clock; asynchronous active-low reset
//   in_sample/in_first/in_valid/in_ready
//                            sample input; in_first marks channel 0
//   audio0..audio3           presented frame
//   out_valid/out_ready      output handshake
//   sync_err                 one-cycle pulse after a framing error
//   err_count                saturating framing error count; it is built only
//                            when AUDIO_SPLITTER_ERRCNT_EN is defined and
//                            is tied to 0 otherwise
module audio_splitter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] in_sample,
  input  logic             in_first,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] audio0,
  output logic [WIDTH-1:0] audio1,
  output logic [WIDTH-1:0] audio2,
  output logic [WIDTH-1:0] audio3,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             sync_err,
  output logic [7:0]       err_count
);

  typedef enum logic {COLLECT, HOLD} state_t;

  state_t           state_q, state_d;
  logic [1:0]       ch_q, ch_d;
  logic [WIDTH-1:0] asm_q [4];
  logic [WIDTH-1:0] asm_d [4];
  logic [WIDTH-1:0] out_q [4];
  logic [WIDTH-1:0] out_d [4];
  logic             out_valid_q, out_valid_d;
  logic             sync_err_q, sync_err_d;
  logic             accept, xfer, load;

  assign in_ready = (state_q == COLLECT);
  assign accept   = in_valid && in_ready;
  assign xfer     = out_valid_q && out_ready;

  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    asm_d      = asm_q;
    out_d      = out_q;
    sync_err_d = 1'b0;
    load       = 1'b0;

    case (state_q)
      COLLECT: begin
        if (accept) begin
          if (in_first) begin
            // A first marker always restarts the frame; a partial frame is lost.
            asm_d[0]   = in_sample;
            ch_d       = 2'd1;
            sync_err_d = (ch_q != 2'd0);
          end else if (ch_q == 2'd0) begin
            sync_err_d = 1'b1;
          end else begin
            asm_d[ch_q] = in_sample;
            ch_d        = ch_q + 2'd1;
            if (ch_q == 2'd3) begin
              // The ch3 sample is bypassed so that the frame is presented after the same edge.
              if (!out_valid_q || xfer) begin
                load     = 1'b1;
                out_d[0] = asm_q[0];
                out_d[1] = asm_q[1];
                out_d[2] = asm_q[2];
                out_d[3] = in_sample;
              end else begin
                state_d = HOLD;
              end
            end
          end
        end
      end
      HOLD: begin
        if (xfer) begin
          load    = 1'b1;
          out_d   = asm_q;
          ch_d    = 2'd0;
          state_d = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase

    if (load)
      out_valid_d = 1'b1;
    else if (xfer)
      out_valid_d = 1'b0;
    else
      out_valid_d = out_valid_q;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= COLLECT;
      ch_q        <= '0;
      out_valid_q <= 1'b0;
      sync_err_q  <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) begin
        asm_q[i] <= '0;
        out_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      out_valid_q <= out_valid_d;
      sync_err_q  <= sync_err_d;
      asm_q       <= asm_d;
      out_q       <= out_d;
    end
  end

  assign audio0    = out_q[0];
  assign audio1    = out_q[1];
  assign audio2    = out_q[2];
  assign audio3    = out_q[3];
  assign out_valid = out_valid_q;
  assign sync_err  = sync_err_q;

`ifdef AUDIO_SPLITTER_ERRCNT_EN
  logic [7:0] err_cnt_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      err_cnt_q <= '0;
    else if (sync_err_d && (err_cnt_q != 8'hFF))
      err_cnt_q <= err_cnt_q + 8'd1;
  end

  assign err_count = err_cnt_q;
`else
  assign err_count = '0;
`endif

endmodule
